// File: rtl/cpu_control_fsm.sv
// Multi-cycle instruction sequencer: fetch -> decode -> execute -> memory -> writeback.
// State and counters are registered; strobes decode from state, the latched op and the acks.
module cpu_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic [10:0]      ALUCtl_code,
  input  logic             execute_flag,
  input  logic             cpsr_enable,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_enable,
  output logic             cpsr_write,
  output logic             reg_write,
  output logic             wb_sel,
  output logic             link_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_error,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [10:0]      op_reg;
  logic             cpsr_en_reg;
  logic [TW-1:0]    timer_reg;
  logic [CNT_W-1:0] count_reg;
  logic             retire;

  logic is_dp, is_cmp, is_b, is_bl, is_ldr, is_str;

  always_comb begin
    is_dp  = 1'b0;
    is_cmp = 1'b0;
    unique case (op_reg)
      11'd0, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7, 11'd11: is_dp  = 1'b1;
      11'd8, 11'd9, 11'd10, 11'd13:                          is_cmp = 1'b1;
      default: ;
    endcase
  end

  assign is_b   = (op_reg == 11'd31);
  assign is_bl  = (op_reg == 11'd32);
  assign is_ldr = (op_reg == 11'd41);
  assign is_str = (op_reg == 11'd42);

  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_enable = 1'b0;
    cpsr_write = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 1'b0;
    link_write = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    mem_error  = 1'b0;
    retire     = 1'b0;
    state_next = state_reg;

    case (state_reg)
      S_IDLE: begin
        if (start && !halt) state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Condition decided on the live decoder output, not the latched copy
        if (!execute_flag) retire = 1'b1;
        else               state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_enable = 1'b1;
        if (is_dp) begin
          cpsr_write = cpsr_en_reg;
          state_next = S_WRITEBACK;
        end else if (is_cmp) begin
          cpsr_write = 1'b1;
          retire     = 1'b1;
        end else if (is_b || is_bl) begin
          pc_src     = 1'b1;
          link_write = is_bl;
          retire     = 1'b1;
        end else if (is_ldr || is_str) begin
          state_next = S_MEMORY;
        end else begin
          illegal_op = 1'b1;
          retire     = 1'b1;
        end
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = is_str;
        if (dmem_ack) begin
          if (is_ldr) state_next = S_WRITEBACK;
          else        retire     = 1'b1;
        end else if (timer_reg <= TW'(1)) begin
          // Final wait cycle: abort without retiring
          mem_error  = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        reg_write = 1'b1;
        wb_sel    = is_ldr;
        retire    = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase

    if (retire) begin
      instr_done = 1'b1;
      pc_write   = 1'b1;
      state_next = halt ? S_IDLE : S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      cpsr_en_reg <= 1'b0;
      timer_reg   <= '0;
      count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        op_reg      <= ALUCtl_code;
        cpsr_en_reg <= cpsr_enable;
      end
      if (state_reg == S_EXECUTE)
        timer_reg <= TW'(MEM_TIMEOUT);
      else if (state_reg == S_MEMORY && !dmem_ack && timer_reg != '0)
        timer_reg <= timer_reg - TW'(1);
      if (retire) count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign state       = state_reg;
  assign busy        = (state_reg != S_IDLE);
  assign instr_count = count_reg;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: per-cycle state and strobe vectors checked
// against hand-computed expectations.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n, start, halt, imem_ack, dmem_ack, execute_flag, cpsr_enable;
  logic [10:0] ALUCtl_code;
  logic        imem_req, ir_write, dmem_req, dmem_we, alu_enable, cpsr_write, reg_write;
  logic        wb_sel, link_write, pc_write, pc_src, instr_done, illegal_op, mem_error, busy;
  logic [31:0] instr_count;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  // Strobe vector bit positions
  localparam logic [13:0] IMEM = 14'h2000, IRW  = 14'h1000, DREQ = 14'h0800, DWE  = 14'h0400;
  localparam logic [13:0] ALU  = 14'h0200, CPSR = 14'h0100, REGW = 14'h0080, WBS  = 14'h0040;
  localparam logic [13:0] LINK = 14'h0020, PCW  = 14'h0010, PCS  = 14'h0008, DONE = 14'h0004;
  localparam logic [13:0] ILL  = 14'h0002, MERR = 14'h0001, NONE = 14'h0000;

  logic [13:0] strb;
  assign strb = {imem_req, ir_write, dmem_req, dmem_we, alu_enable, cpsr_write, reg_write,
                 wb_sel, link_write, pc_write, pc_src, instr_done, illegal_op, mem_error};

  cpu_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .ALUCtl_code(ALUCtl_code),
    .execute_flag(execute_flag), .cpsr_enable(cpsr_enable),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .alu_enable(alu_enable), .cpsr_write(cpsr_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .link_write(link_write), .pc_write(pc_write), .pc_src(pc_src),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_error(mem_error),
    .busy(busy), .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs for the cycle are already applied; settle, check, advance to next cycle
  task automatic cyc(input string tag, input logic [2:0] es, input logic [13:0] ex);
    #1;
    chk({tag, "_state"}, {29'd0, state}, {29'd0, es});
    chk({tag, "_strb"}, {18'd0, strb}, {18'd0, ex});
    $display("cycle %-10s state=%0d strobes=%04h count=%0d", tag, state, strb, instr_count);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b0;
    ALUCtl_code = 11'd0; execute_flag = 1'b1; cpsr_enable = 1'b1;
    #3;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_strb", {18'd0, strb}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // ADD with S bit; inputs changed after DECODE to prove they are latched
    start = 1'b1;
    cyc("add_idle", 3'd0, NONE);
    start = 1'b0;
    cyc("add_fetch", 3'd1, IMEM | IRW);
    cyc("add_dec", 3'd2, NONE);
    ALUCtl_code = 11'd42; cpsr_enable = 1'b0;
    cyc("add_exec", 3'd3, ALU | CPSR);
    cyc("add_wb", 3'd5, REGW | PCW | DONE);
    chk("add_count", instr_count, 32'd1);

    // BL retires in EXECUTE
    ALUCtl_code = 11'd32;
    cyc("bl_fetch", 3'd1, IMEM | IRW);
    cyc("bl_dec", 3'd2, NONE);
    cyc("bl_exec", 3'd3, ALU | LINK | PCW | PCS | DONE);
    chk("bl_count", instr_count, 32'd2);

    // CMP writes flags even with S=0
    ALUCtl_code = 11'd8; cpsr_enable = 1'b0;
    cyc("cmp_fetch", 3'd1, IMEM | IRW);
    cyc("cmp_dec", 3'd2, NONE);
    cyc("cmp_exec", 3'd3, ALU | CPSR | PCW | DONE);
    chk("cmp_count", instr_count, 32'd3);

    // LDR with dmem_ack on the 4th MEMORY cycle: 8 cycles total
    ALUCtl_code = 11'd41;
    cyc("ldr_fetch", 3'd1, IMEM | IRW);
    cyc("ldr_dec", 3'd2, NONE);
    cyc("ldr_exec", 3'd3, ALU);
    cyc("ldr_mem1", 3'd4, DREQ);
    cyc("ldr_mem2", 3'd4, DREQ);
    cyc("ldr_mem3", 3'd4, DREQ);
    dmem_ack = 1'b1;
    cyc("ldr_mem4", 3'd4, DREQ);
    dmem_ack = 1'b0;
    cyc("ldr_wb", 3'd5, REGW | WBS | PCW | DONE);
    chk("ldr_count", instr_count, 32'd4);

    // STR with no ack: abort on the 16th MEMORY cycle
    ALUCtl_code = 11'd42;
    cyc("str_fetch", 3'd1, IMEM | IRW);
    cyc("str_dec", 3'd2, NONE);
    cyc("str_exec", 3'd3, ALU);
    for (int i = 1; i <= 15; i++) cyc($sformatf("str_m%0d", i), 3'd4, DREQ | DWE);
    cyc("str_m16", 3'd4, DREQ | DWE | MERR);
    chk("str_count", instr_count, 32'd4);
    cyc("str_idle", 3'd0, NONE);

    // Branch with failed condition retires in DECODE; halt returns to IDLE
    start = 1'b1; ALUCtl_code = 11'd31; execute_flag = 1'b0;
    cyc("cf_idle", 3'd0, NONE);
    start = 1'b0;
    cyc("cf_fetch", 3'd1, IMEM | IRW);
    halt = 1'b1;
    cyc("cf_dec", 3'd2, PCW | DONE);
    chk("cf_count", instr_count, 32'd5);
    // halt beats start in IDLE
    start = 1'b1;
    cyc("hw_idle1", 3'd0, NONE);
    cyc("hw_idle2", 3'd0, NONE);
    halt = 1'b0;

    // Illegal code 20, with one stalled fetch cycle
    ALUCtl_code = 11'd20; execute_flag = 1'b1; imem_ack = 1'b0;
    cyc("il_idle", 3'd0, NONE);
    start = 1'b0;
    cyc("il_fwait", 3'd1, IMEM);
    imem_ack = 1'b1;
    cyc("il_fetch", 3'd1, IMEM | IRW);
    cyc("il_dec", 3'd2, NONE);
    cyc("il_exec", 3'd3, ALU | PCW | DONE | ILL);
    chk("il_count", instr_count, 32'd6);

    // Reset while a store is outstanding
    ALUCtl_code = 11'd42;
    cyc("rs_fetch", 3'd1, IMEM | IRW);
    cyc("rs_dec", 3'd2, NONE);
    cyc("rs_exec", 3'd3, ALU);
    #1;
    chk("rs_dreq_before", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_dreq_after", {31'd0, dmem_req}, 32'd0);
    chk("rs_state", {29'd0, state}, 32'd0);
    chk("rs_count", instr_count, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1; start = 1'b1;
    cyc("rs_idle", 3'd0, NONE);
    start = 1'b0;
    cyc("rs_fetch2", 3'd1, IMEM | IRW);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
